ppu_reg_snoop: RTL and testbench
================================

// Module: ppu_reg_snoop
// PURPOSE
//  Passive PPU B-bus write snooper feeding the RGB scaling/OSD stage and the mode-7 overlay logic.
//  - Filters and synchronises PAWR, PADDRESS and DATA.
//  - Decodes writes to INIDISP ($2100), BGMODE ($2105), M7SEL ($211A) and SETINI ($2133).
//  - Presents clean, optionally line-synchronous display state downstream.
// PARAMETERS
//  SYNC_STAGES  2  flops in each input synchroniser chain (PAWR, HBLANK, VBLANK)
//  MIN_STROBE   2  synchronised PAWR-low clocks required before a strobe counts as a write
//  LINE_SYNC    1  1: display outputs update on the next HBLANK rise; 0: update on commit
// PORTS
//  CLK_i           in   1  master clock (MCLKO domain)
//  NRST_i          in   1  asynchronous active-low reset
//  PAWR_i          in   1  B-bus write strobe, active low, asynchronous to CLK_i
//  PADDRESS_i      in   8  B-bus address
//  DATA_i          in   8  B-bus data
//  HBLANK_i        in   1  horizontal blank, asynchronous
//  VBLANK_i        in   1  vertical blank, asynchronous
//  brightness_o    out  4  INIDISP[3:0]
//  force_blank_o   out  1  INIDISP[7]
//  bg_mode_o       out  3  BGMODE[2:0]
//  mode7_over_o    out  1  (bg_mode_o==7) & (M7SEL[7:6]==2'b10)
//  pseudo_hires_o  out  1  SETINI[3]
//  overscan_o      out  1  SETINI[2]
//  interlace_o     out  1  SETINI[0]
//  field_o         out  1  interlace field flag
//  wr_pulse_o      out  1  one-clock pulse per committed write, any address
//  wr_addr_o       out  8  address of the last committed write
//  wr_data_o       out  8  data of the last committed write
// BEHAVIOUR
//  Reset values (async on NRST_i low):
//  - brightness_o=4'hF; every other output 0; FSM in WAIT_HIGH; pending registers cleared.
//  Input capture:
//  - PAWR, HBLANK and VBLANK pass through SYNC_STAGES flops.
//  - PADDRESS and DATA are sampled raw only in the capture cycle below.
//  FSM:
//  - WAIT_HIGH: stay until sync PAWR=1, then IDLE.
//    Guarantees a strobe already in progress when reset is released is ignored.
//  - IDLE: sync PAWR=0 -> LOW_CNT, cnt=1.
//  - LOW_CNT: PAWR=0 -> cnt++.
//    When cnt reaches MIN_STROBE: latch PADDRESS/DATA, go to CAPTURED.
//    PAWR=1 before that -> glitch; go to IDLE, no commit.
//  - CAPTURED: on sync PAWR rising -> COMMIT for 1 clk, then IDLE.
//  Commit:
//  - wr_pulse_o=1 for exactly one clock.
//  - wr_addr_o and wr_data_o hold the latched values until the next commit.
//  - Decoded register fields go to pending shadows; unmatched addresses update only the wr_* outputs.
//  - Latency, sync PAWR rise to wr_pulse_o: 1 clock.
//  - LINE_SYNC=0: display outputs take pending values in the same cycle as wr_pulse_o.
//  - LINE_SYNC=1: display outputs take pending values on the clock after a sync HBLANK rising edge.
//  - Commit coinciding with an HBLANK rise: the new value is applied at that rise (bypass).
//    Newest value wins; no write is lost.
//  - Several writes within one line: only the last value per field becomes visible.
//  mode7_over_o:
//  - Computed from the active bg_mode_o and the active M7SEL[7:6]; registered.
//  field_o:
//  - Toggles on each sync VBLANK rising edge while interlace_o=1.
//  - Forced to 0 in the cycle interlace_o becomes 0.
//  Reset mid-operation:
//  - Everything returns to reset values immediately; a partial capture is discarded.
//  Widths:
//  - Strobe counter is clog2(MIN_STROBE)+1 bits and saturates at MIN_STROBE; no wrap on long strobes.
// STRUCTURE
//  Shared package snes_tst_pkg holds:
//  - Address constants ADDR_INIDISP=8'h00, ADDR_BGMODE=8'h05, ADDR_M7SEL=8'h1A, ADDR_SETINI=8'h33.
//  - FSM state enum {WAIT_HIGH, IDLE, LOW_CNT, CAPTURED, COMMIT}.
//  - Reset constant BRIGHTNESS_RST=4'hF.
//  Sub-module sync_ff (parameter STAGES, 1-bit, async active-low reset to 0), instantiated 3 times.
//  Decode, shadows and FSM stay in this module.
// TESTING
//  - Reset, then write $00 <- 8'h8A with PAWR low 6 clocks (LINE_SYNC=0)
//    -> wr_pulse_o 1 clk after sync rise; brightness_o=4'hA, force_blank_o=1.
//  - PAWR low for only 1 clock (MIN_STROBE=2)
//    -> no wr_pulse_o; all outputs unchanged.
//  - LINE_SYNC=1: write $00 <- 8'h03 mid-line
//    -> brightness_o stays F until the clock after the next HBLANK rise, then 3.
//    Repeat with the commit on the same clock as the HBLANK rise -> 3 at that rise.
//  - Write $05 <- 8'h07, then $1A <- 8'h80
//    -> mode7_over_o=1.
//    Then write $1A <- 8'hC0 -> mode7_over_o=0.
//  - Write $33 <- 8'h01, then 3 VBLANK rises
//    -> field_o toggles 1,0,1.
//    Then write $33 <- 8'h00 -> field_o=0 and interlace_o=0.
//  - Assert NRST_i while PAWR is low, then release it with PAWR still low
//    -> no commit for that strobe; the next full write commits normally.

Source files
------------

// File: rtl/ppu_reg_snoop_pkg.sv
// Shared constants, FSM state encoding and the display-state record for the PPU write snooper.
package snes_tst_pkg;

    localparam logic [7:0] ADDR_INIDISP   = 8'h00;
    localparam logic [7:0] ADDR_BGMODE    = 8'h05;
    localparam logic [7:0] ADDR_M7SEL     = 8'h1A;
    localparam logic [7:0] ADDR_SETINI    = 8'h33;
    localparam logic [3:0] BRIGHTNESS_RST = 4'hF;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        LOW_CNT,
        CAPTURED,
        COMMIT
    } snoop_state_e;

    typedef struct packed {
        logic       force_blank;
        logic [3:0] brightness;
        logic [2:0] bg_mode;
        logic [1:0] m7sel_hi;
        logic       pseudo_hires;
        logic       overscan;
        logic       interlace;
    } disp_t;

    localparam disp_t DISP_RST = '{
        force_blank:  1'b0,
        brightness:   BRIGHTNESS_RST,
        bg_mode:      3'd0,
        m7sel_hi:     2'd0,
        pseudo_hires: 1'b0,
        overscan:     1'b0,
        interlace:    1'b0
    };

    // Merge one B-bus write into a display record; unknown addresses leave it untouched.
    function automatic disp_t apply_write(disp_t cur, logic [7:0] addr, logic [7:0] data);
        disp_t nxt;
        nxt = cur;
        case (addr)
            ADDR_INIDISP: begin
                nxt.force_blank = data[7];
                nxt.brightness  = data[3:0];
            end
            ADDR_BGMODE:  nxt.bg_mode  = data[2:0];
            ADDR_M7SEL:   nxt.m7sel_hi = data[7:6];
            ADDR_SETINI: begin
                nxt.pseudo_hires = data[3];
                nxt.overscan     = data[2];
                nxt.interlace    = data[0];
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ppu_reg_snoop_if.sv
// PPU B-bus write-side signals as seen by a passive observer.
interface ppu_reg_snoop_if;
    logic       PAWR_i;
    logic [7:0] PADDRESS_i;
    logic [7:0] DATA_i;

    modport master (output PAWR_i, PADDRESS_i, DATA_i);
    modport slave  (input  PAWR_i, PADDRESS_i, DATA_i);
endinterface

// File: rtl/ppu_reg_snoop_sync.sv
// Single-bit multi-flop synchroniser, clears to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK_i,
    input  logic NRST_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/ppu_reg_snoop.sv
// Passive PPU B-bus write snooper: filters PAWR strobes, decodes display registers and
// presents them (optionally deferred to the next HBLANK) to the scaler/OSD stage.
//
// state     | meaning
// WAIT_HIGH | after reset, ignore any strobe already in flight until PAWR is seen high
// IDLE      | waiting for PAWR to fall
// LOW_CNT   | counting PAWR-low clocks to reject glitches
// CAPTURED  | address/data latched, waiting for PAWR to rise
// COMMIT    | one-clock write commit (wr_pulse_o)
module ppu_reg_snoop
    import snes_tst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_STROBE  = 2,
    parameter bit LINE_SYNC   = 1'b1
) (
    input  logic            CLK_i,
    input  logic            NRST_i,
    ppu_reg_snoop_if.slave  bbus_i,
    input  logic            HBLANK_i,
    input  logic            VBLANK_i,
    output logic [3:0]      brightness_o,
    output logic            force_blank_o,
    output logic [2:0]      bg_mode_o,
    output logic            mode7_over_o,
    output logic            pseudo_hires_o,
    output logic            overscan_o,
    output logic            interlace_o,
    output logic            field_o,
    output logic            wr_pulse_o,
    output logic [7:0]      wr_addr_o,
    output logic [7:0]      wr_data_o
);
    localparam int               CNT_W   = $clog2(MIN_STROBE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_STROBE);

    logic pawr_s, hblank_s, vblank_s;
    logic hblank_s_q, vblank_s_q;
    logic hb_rise, vb_rise;

    snoop_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lat_addr_q, lat_addr_d, lat_data_q, lat_data_d;
    logic [7:0]       wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic             commit;
    disp_t            pend_q, pend_d, disp_q, disp_d;
    logic             mode7_q, mode7_d, field_q, field_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pawr (
        .CLK_i(CLK_i), .NRST_i(NRST_i), .d_i(bbus_i.PAWR_i), .q_o(pawr_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hblank (
        .CLK_i(CLK_i), .NRST_i(NRST_i), .d_i(HBLANK_i), .q_o(hblank_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_vblank (
        .CLK_i(CLK_i), .NRST_i(NRST_i), .d_i(VBLANK_i), .q_o(vblank_s));

    assign hb_rise = hblank_s & ~hblank_s_q;
    assign vb_rise = vblank_s & ~vblank_s_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        lat_data_d = lat_data_q;
        commit     = 1'b0;
        case (state_q)
            WAIT_HIGH: if (pawr_s) state_d = IDLE;
            IDLE: begin
                if (!pawr_s) begin
                    state_d = LOW_CNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOW_CNT: begin
                if (pawr_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        lat_addr_d = bbus_i.PADDRESS_i;
                        lat_data_d = bbus_i.DATA_i;
                        state_d    = CAPTURED;
                    end
                end
            end
            CAPTURED: begin
                if (pawr_s) begin
                    state_d = COMMIT;
                    commit  = 1'b1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = WAIT_HIGH;
        endcase
    end

    // Commit lands on the edge into COMMIT so every output is valid while wr_pulse_o is high.
    always_comb begin
        wr_addr_d = commit ? lat_addr_q : wr_addr_q;
        wr_data_d = commit ? lat_data_q : wr_data_q;
        pend_d    = commit ? apply_write(pend_q, lat_addr_q, lat_data_q) : pend_q;
        if (LINE_SYNC) disp_d = hb_rise ? pend_d : disp_q;
        else           disp_d = pend_d;
        mode7_d = (disp_d.bg_mode == 3'd7) && (disp_d.m7sel_hi == 2'b10);
        if (!disp_d.interlace)               field_d = 1'b0;
        else if (vb_rise && disp_q.interlace) field_d = ~field_q;
        else                                 field_d = field_q;
    end

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            state_q    <= WAIT_HIGH;
            cnt_q      <= '0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pend_q     <= DISP_RST;
            disp_q     <= DISP_RST;
            mode7_q    <= 1'b0;
            field_q    <= 1'b0;
            hblank_s_q <= 1'b0;
            vblank_s_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            mode7_q    <= mode7_d;
            field_q    <= field_d;
            hblank_s_q <= hblank_s;
            vblank_s_q <= vblank_s;
        end
    end

    assign brightness_o   = disp_q.brightness;
    assign force_blank_o  = disp_q.force_blank;
    assign bg_mode_o      = disp_q.bg_mode;
    assign mode7_over_o   = mode7_q;
    assign pseudo_hires_o = disp_q.pseudo_hires;
    assign overscan_o     = disp_q.overscan;
    assign interlace_o    = disp_q.interlace;
    assign field_o        = field_q;
    assign wr_pulse_o     = (state_q == COMMIT);
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
endmodule

// File: tb/tb_ppu_reg_snoop.sv
// Directed bench: one snooper with immediate display update, one with line-synchronous update.
module tb_ppu_reg_snoop;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hblank = 1'b0;
    logic vblank = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pulses0 = 0;
    int   pulses1 = 0;
    int   snap0, snap1;

    ppu_reg_snoop_if bus ();

    logic [3:0] bright0, bright1;
    logic       fblank0, fblank1;
    logic [2:0] bgmode0, bgmode1;
    logic       m7_0, m7_1, phires0, phires1, ovs0, ovs1, intl0, intl1, field0, field1;
    logic       pulse0, pulse1;
    logic [7:0] waddr0, waddr1, wdata0, wdata1;

    ppu_reg_snoop #(.SYNC_STAGES(2), .MIN_STROBE(2), .LINE_SYNC(1'b0)) dut0 (
        .CLK_i(clk), .NRST_i(rst_n), .bbus_i(bus), .HBLANK_i(hblank), .VBLANK_i(vblank),
        .brightness_o(bright0), .force_blank_o(fblank0), .bg_mode_o(bgmode0),
        .mode7_over_o(m7_0), .pseudo_hires_o(phires0), .overscan_o(ovs0),
        .interlace_o(intl0), .field_o(field0), .wr_pulse_o(pulse0),
        .wr_addr_o(waddr0), .wr_data_o(wdata0));

    ppu_reg_snoop #(.SYNC_STAGES(2), .MIN_STROBE(2), .LINE_SYNC(1'b1)) dut1 (
        .CLK_i(clk), .NRST_i(rst_n), .bbus_i(bus), .HBLANK_i(hblank), .VBLANK_i(vblank),
        .brightness_o(bright1), .force_blank_o(fblank1), .bg_mode_o(bgmode1),
        .mode7_over_o(m7_1), .pseudo_hires_o(phires1), .overscan_o(ovs1),
        .interlace_o(intl1), .field_o(field1), .wr_pulse_o(pulse1),
        .wr_addr_o(waddr1), .wr_data_o(wdata1));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pulse0) pulses0++;
        if (pulse1) pulses1++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench one clock before the commit edge.
    task automatic strobe(input logic [7:0] a, input logic [7:0] d, input int low, input bit with_hb);
        bus.PADDRESS_i = a;
        bus.DATA_i     = d;
        bus.PAWR_i     = 1'b0;
        step(low);
        bus.PAWR_i = 1'b1;
        if (with_hb) hblank = 1'b1;
        step(2);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        strobe(a, d, 3, 1'b0);
        chk("pulse_early", pulse0, 1'b0);
        step(1);
        chk("pulse", pulse0, 1'b1);
        chk("wr_addr", waddr0, a);
        chk("wr_data", wdata0, d);
        step(1);
        chk("pulse_end", pulse0, 1'b0);
    endtask

    initial begin
        bus.PAWR_i     = 1'b1;
        bus.PADDRESS_i = 8'h00;
        bus.DATA_i     = 8'h00;
        step(3);
        chk("rst_bright0", bright0, 4'hF);
        chk("rst_bright1", bright1, 4'hF);
        chk("rst_fblank", fblank0, 1'b0);
        chk("rst_bgmode", bgmode0, 3'd0);
        chk("rst_m7", m7_0, 1'b0);
        chk("rst_intl", intl0, 1'b0);
        chk("rst_field", field0, 1'b0);
        chk("rst_pulse", pulse0, 1'b0);
        chk("rst_waddr", waddr0, 8'h00);
        rst_n = 1'b1;
        step(4);

        // INIDISP with a long strobe, immediate update
        strobe(8'h00, 8'h8A, 6, 1'b0);
        chk("w1_pulse_early", pulse0, 1'b0);
        step(1);
        chk("w1_pulse", pulse0, 1'b1);
        chk("w1_bright0", bright0, 4'hA);
        chk("w1_fblank0", fblank0, 1'b1);
        chk("w1_wdata0", wdata0, 8'h8A);
        chk("w1_bright1_held", bright1, 4'hF);
        step(1);
        chk("w1_pulse_end", pulse0, 1'b0);

        // one-clock glitch is not a write
        snap0 = pulses0;
        snap1 = pulses1;
        bus.PADDRESS_i = 8'h00;
        bus.DATA_i     = 8'h01;
        bus.PAWR_i     = 1'b0;
        step(1);
        bus.PAWR_i = 1'b1;
        step(8);
        chk("glitch_pulses0", pulses0, snap0);
        chk("glitch_pulses1", pulses1, snap1);
        chk("glitch_bright0", bright0, 4'hA);
        chk("glitch_wdata0", wdata0, 8'h8A);

        // line-synchronous update, write mid-line
        strobe(8'h00, 8'h03, 3, 1'b0);
        step(1);
        chk("ls_pulse1", pulse1, 1'b1);
        chk("ls_bright0", bright0, 4'h3);
        chk("ls_bright1_commit", bright1, 4'hF);
        step(5);
        chk("ls_bright1_line", bright1, 4'hF);
        hblank = 1'b1;
        step(2);
        chk("ls_bright1_hbsync", bright1, 4'hF);
        step(1);
        chk("ls_bright1_applied", bright1, 4'h3);
        chk("ls_fblank1_last", fblank1, 1'b0);
        hblank = 1'b0;
        step(4);

        // commit on the same clock as the HBLANK rise
        strobe(8'h00, 8'h05, 3, 1'b1);
        chk("byp_before", bright1, 4'h3);
        step(1);
        chk("byp_pulse1", pulse1, 1'b1);
        chk("byp_bright1", bright1, 4'h5);
        hblank = 1'b0;
        step(4);

        // mode-7 overlay decode
        write_reg(8'h05, 8'h07);
        write_reg(8'h1A, 8'h80);
        chk("m7_bgmode", bgmode0, 3'd7);
        chk("m7_on", m7_0, 1'b1);
        write_reg(8'h1A, 8'hC0);
        chk("m7_off", m7_0, 1'b0);
        write_reg(8'h99, 8'h55);
        chk("unmapped_bgmode", bgmode0, 3'd7);

        // SETINI fields and interlace field toggling
        write_reg(8'h33, 8'h0C);
        chk("setini_phires", phires0, 1'b1);
        chk("setini_ovs", ovs0, 1'b1);
        chk("setini_intl", intl0, 1'b0);
        write_reg(8'h33, 8'h01);
        chk("intl_on", intl0, 1'b1);
        chk("field_start", field0, 1'b0);
        vblank = 1'b1; step(3);
        chk("field_1", field0, 1'b1);
        vblank = 1'b0; step(3);
        vblank = 1'b1; step(3);
        chk("field_2", field0, 1'b0);
        vblank = 1'b0; step(3);
        vblank = 1'b1; step(3);
        chk("field_3", field0, 1'b1);
        vblank = 1'b0; step(3);
        strobe(8'h33, 8'h00, 3, 1'b0);
        chk("field_hold", field0, 1'b1);
        step(1);
        chk("intl_off", intl0, 1'b0);
        chk("field_forced", field0, 1'b0);
        step(2);

        // reset asserted and released while PAWR is low
        bus.PADDRESS_i = 8'h00;
        bus.DATA_i     = 8'h0F;
        bus.PAWR_i     = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(2);
        chk("mid_rst_bright", bright0, 4'hF);
        chk("mid_rst_waddr", waddr0, 8'h00);
        chk("mid_rst_m7", m7_0, 1'b0);
        rst_n = 1'b1;
        step(4);
        snap0 = pulses0;
        snap1 = pulses1;
        bus.PAWR_i = 1'b1;
        step(8);
        chk("mid_rst_pulses0", pulses0, snap0);
        chk("mid_rst_pulses1", pulses1, snap1);
        chk("mid_rst_bright_hold", bright0, 4'hF);
        write_reg(8'h00, 8'h07);
        chk("after_rst_bright", bright0, 4'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
